// File: rtl/accumulator_binary_saturating_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : accumulator_binary_saturating_pkg
//  Brief    : Shared types for the saturating accumulator output slot.
//  Revision : 1.0 - initial release
// ============================================================================
package accumulator_binary_saturating_pkg;

    // Output slot occupancy; a single register bit in the top level.
    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage : accumulator_binary_saturating_pkg
`default_nettype wire

// File: rtl/accumulator_binary_saturating_adder_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : Adder_Subtractor_Binary_Saturating
//  Brief    : Signed add/subtract on WORD_WIDTH+1 bits, clipped to limits.
//  Revision : 1.0 - initial release
// ============================================================================
module Adder_Subtractor_Binary_Saturating #(
    parameter int WORD_WIDTH = 8
) (
    input  logic [WORD_WIDTH-1:0] max_limit,
    input  logic [WORD_WIDTH-1:0] min_limit,
    input  logic                  add_sub,
    input  logic                  carry_in,
    input  logic [WORD_WIDTH-1:0] a,
    input  logic [WORD_WIDTH-1:0] b,
    output logic [WORD_WIDTH-1:0] sum,
    output logic                  carry_out,
    output logic                  saturated
);

    localparam int c_ext_width = WORD_WIDTH + 1;

    logic signed [c_ext_width-1:0] w_a_ext;
    logic signed [c_ext_width-1:0] w_b_ext;
    logic signed [c_ext_width-1:0] w_cin_ext;
    logic signed [c_ext_width-1:0] w_max_ext;
    logic signed [c_ext_width-1:0] w_min_ext;
    logic signed [c_ext_width-1:0] w_raw;
    logic                          w_over;
    logic                          w_under;

    // One guard bit is enough: the extreme a-b or a+b never leaves this range.
    assign w_a_ext   = {a[WORD_WIDTH-1], a};
    assign w_b_ext   = {b[WORD_WIDTH-1], b};
    assign w_cin_ext = {{WORD_WIDTH{1'b0}}, carry_in};
    assign w_max_ext = {max_limit[WORD_WIDTH-1], max_limit};
    assign w_min_ext = {min_limit[WORD_WIDTH-1], min_limit};

    assign w_raw = add_sub ? (w_a_ext - w_b_ext - w_cin_ext)
                           : (w_a_ext + w_b_ext + w_cin_ext);

    assign w_over  = (w_raw > w_max_ext);
    assign w_under = (w_raw < w_min_ext);

    always_comb begin
        sum = w_raw[WORD_WIDTH-1:0];
        if (w_over) begin
            sum = max_limit;
        end else if (w_under) begin
            sum = min_limit;
        end
    end

    assign carry_out = w_raw[WORD_WIDTH];
    assign saturated = w_over | w_under;

endmodule : Adder_Subtractor_Binary_Saturating
`default_nettype wire

// File: rtl/accumulator_binary_saturating.sv
`default_nettype none
// ============================================================================
//  Module   : accumulator_binary_saturating
//  Brief    : Ready/valid signed accumulator with programmable clip limits.
//  Revision : 1.0 - initial release
// ============================================================================
module accumulator_binary_saturating
    import accumulator_binary_saturating_pkg::*;
#(
    parameter int                    WORD_WIDTH    = 8,
    parameter logic [WORD_WIDTH-1:0] INITIAL_VALUE = '0
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [WORD_WIDTH-1:0] max_limit,
    input  logic [WORD_WIDTH-1:0] min_limit,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_add_sub,
    input  logic                  in_load,
    input  logic [WORD_WIDTH-1:0] in_increment,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_total,
    output logic                  out_carry,
    output logic                  out_saturated
);

    slot_state_t             r_state;
    slot_state_t             w_state_next;
    logic [WORD_WIDTH-1:0]   r_total;
    logic                    r_carry;
    logic                    r_saturated;
    logic                    w_accept;
    logic                    w_consume;
    logic [WORD_WIDTH-1:0]   w_sum;
    logic                    w_carry;
    logic                    w_saturated;

    Adder_Subtractor_Binary_Saturating #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_addsub (
        .max_limit  (max_limit),
        .min_limit  (min_limit),
        .add_sub    (in_add_sub),
        .carry_in   (1'b0),
        .a          (r_total),
        .b          (in_increment),
        .sum        (w_sum),
        .carry_out  (w_carry),
        .saturated  (w_saturated)
    );

    // A full slot may refill in the same cycle it drains.
    assign in_ready  = !clear && ((r_state == SLOT_EMPTY) || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_consume = (r_state == SLOT_FULL) && out_ready;

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= SLOT_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            w_state_next = SLOT_FULL;
        end else if (w_consume) begin
            w_state_next = SLOT_EMPTY;
        end
    end

    // The total persists across consumes; only accepts and clear move it.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_total     <= INITIAL_VALUE;
            r_carry     <= 1'b0;
            r_saturated <= 1'b0;
        end else if (w_accept) begin
            if (in_load) begin
                r_total     <= in_increment;
                r_carry     <= 1'b0;
                r_saturated <= 1'b0;
            end else begin
                r_total     <= w_sum;
                r_carry     <= w_carry;
                r_saturated <= w_saturated;
            end
        end
    end

    assign out_valid     = (r_state == SLOT_FULL);
    assign out_total     = r_total;
    assign out_carry     = r_carry;
    assign out_saturated = r_saturated;

endmodule : accumulator_binary_saturating
`default_nettype wire

// File: tb/tb_accumulator_binary_saturating.sv
`default_nettype none
// ============================================================================
//  Module   : tb_accumulator_binary_saturating
//  Brief    : Directed and random checks against an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_accumulator_binary_saturating;

    localparam int W    = 8;
    localparam int INIT = 0;

    logic         clock = 1'b0;
    logic         clear;
    logic [W-1:0] max_limit;
    logic [W-1:0] min_limit;
    logic         in_valid;
    logic         in_ready;
    logic         in_add_sub;
    logic         in_load;
    logic [W-1:0] in_increment;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_total;
    logic         out_carry;
    logic         out_saturated;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain integer arithmetic on the documented rules.
    bit m_full  = 1'b0;
    int m_total = INIT;
    bit m_carry = 1'b0;
    bit m_sat   = 1'b0;

    accumulator_binary_saturating #(
        .WORD_WIDTH    (W),
        .INITIAL_VALUE (W'(INIT))
    ) dut (
        .clock         (clock),
        .clear         (clear),
        .max_limit     (max_limit),
        .min_limit     (min_limit),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_add_sub    (in_add_sub),
        .in_load       (in_load),
        .in_increment  (in_increment),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_total     (out_total),
        .out_carry     (out_carry),
        .out_saturated (out_saturated)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle(input string tag, input bit clr, input bit iv,
                         input bit sub, input bit ld, input int inc,
                         input int maxl, input int minl, input bit ordy);
        bit exp_rdy;
        int s;
        clear        = clr;
        in_valid     = iv;
        in_add_sub   = sub;
        in_load      = ld;
        in_increment = W'(inc);
        max_limit    = W'(maxl);
        min_limit    = W'(minl);
        out_ready    = ordy;
        #1;
        exp_rdy = !clr && (!m_full || ordy);
        check({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, exp_rdy});
        @(posedge clock);
        if (clr) begin
            m_full = 0; m_total = INIT; m_carry = 0; m_sat = 0;
        end else if (iv && exp_rdy) begin
            m_full = 1;
            if (ld) begin
                m_total = inc; m_carry = 0; m_sat = 0;
            end else begin
                s       = sub ? (m_total - inc) : (m_total + inc);
                m_carry = s[W];
                m_sat   = (s > maxl) || (s < minl);
                m_total = (s > maxl) ? maxl : ((s < minl) ? minl : s);
            end
        end else if (m_full && ordy) begin
            m_full = 0;
        end
        #1;
        check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, m_full});
        check({tag, ".out_total"}, $signed(out_total), m_total);
        check({tag, ".out_carry"}, {31'd0, out_carry}, {31'd0, m_carry});
        check({tag, ".out_saturated"}, {31'd0, out_saturated}, {31'd0, m_sat});
    endtask

    initial begin
        int a;
        int b;
        clear = 1'b1; in_valid = 0; in_add_sub = 0; in_load = 0;
        in_increment = '0; max_limit = W'(100); min_limit = W'(-100); out_ready = 1;

        cycle("reset0", 1, 1, 0, 0, 5, 100, -100, 1);
        cycle("reset1", 1, 0, 0, 0, 0, 100, -100, 1);
        check("reset.total_const", $signed(out_total), 0);
        cycle("idle", 0, 0, 0, 0, 0, 100, -100, 1);

        cycle("add50a", 0, 1, 0, 0, 50, 100, -100, 1);
        check("add50a.const", $signed(out_total), 50);
        cycle("add50b", 0, 1, 0, 0, 50, 100, -100, 1);
        check("add50b.const", $signed(out_total), 100);
        cycle("drain", 0, 0, 0, 0, 0, 100, -100, 1);
        check("drain.valid_const", {31'd0, out_valid}, 0);

        cycle("add60", 0, 1, 0, 0, 60, 100, -100, 1);
        check("add60.sat_const", {31'd0, out_saturated}, 1);
        cycle("sub30", 0, 1, 1, 0, 30, 100, -100, 1);
        check("sub30.const", $signed(out_total), 70);

        cycle("load_m90", 0, 1, 0, 1, -90, 100, -100, 1);
        cycle("sub20", 0, 1, 1, 0, 20, 100, -100, 1);
        check("sub20.const", $signed(out_total), -100);
        check("sub20.carry_const", {31'd0, out_carry}, 1);

        cycle("load127", 0, 1, 0, 1, 127, 127, -100, 1);
        cycle("add1", 0, 1, 0, 0, 1, 127, -100, 1);
        check("add1.const", $signed(out_total), 127);
        check("add1.sat_const", {31'd0, out_saturated}, 1);

        cycle("load0", 0, 1, 0, 1, 0, 100, -100, 1);
        cycle("bp_acc10", 0, 1, 0, 0, 10, 100, -100, 1);
        for (int i = 0; i < 3; i++) begin
            cycle("bp_hold", 0, 1, 0, 0, 10, 90 - i, -90 + i, 0);
            check("bp_hold.ready_const", {31'd0, in_ready}, 0);
            check("bp_hold.total_const", $signed(out_total), 10);
        end
        cycle("bp_pass", 0, 1, 0, 0, 10, 100, -100, 1);
        check("bp_pass.const", $signed(out_total), 20);

        cycle("full_hold", 0, 1, 0, 0, 5, 100, -100, 0);
        cycle("clear_full", 1, 1, 0, 0, 7, 100, -100, 1);
        check("clear_full.valid_const", {31'd0, out_valid}, 0);
        check("clear_full.total_const", $signed(out_total), 0);
        cycle("after_clear", 0, 0, 0, 0, 0, 100, -100, 1);

        for (int i = 0; i < 300; i++) begin
            a = int'($urandom_range(0, 255)) - 128;
            b = int'($urandom_range(0, 255)) - 128;
            if (a < b) begin
                int t;
                t = a; a = b; b = t;
            end
            cycle("rand", ($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 7) == 0),
                  int'($urandom_range(0, 255)) - 128, a, b,
                  ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_accumulator_binary_saturating
`default_nettype wire
